// File: rtl/iin_table_classifier.sv
// Programmable IIN prefix classifier.
// A table of prefix rules is written through the cfg_* port while idle. After a
// Luhn-valid card completes, the table is scanned LANES entries per cycle and the
// longest matching prefix (lowest index on ties) supplies brand/issuer/type.
// Cards with no matching rule get a brand guessed from the leading digits.
//
// Handshake: cfg_we is accepted on a rising edge only while cfg_ready is high;
// cfg_ready is low for the whole scan/publish window and any write offered then
// is dropped. card_done/start are single-cycle strobes with no back-pressure;
// a card_done that arrives while busy is discarded and flagged via overrun.
module iin_table_classifier #(
  parameter int NUM_ENTRIES   = 32,
  parameter int LANES         = 4,
  parameter int PREFIX_DIGITS = 6,
  parameter int ISSUER_W      = 5,
  parameter int AW            = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       card_done,
  input  logic                       luhn_valid,
  input  logic [4*PREFIX_DIGITS-1:0] prefix_bcd,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [4*PREFIX_DIGITS-1:0] cfg_prefix,
  input  logic [3:0]                 cfg_len,
  input  logic [2:0]                 cfg_brand,
  input  logic [ISSUER_W-1:0]        cfg_issuer,
  input  logic [1:0]                 cfg_type,
  output logic                       cfg_ready,
  output logic                       busy,
  output logic [2:0]                 brand_id,
  output logic [ISSUER_W-1:0]        issuer_id,
  output logic [1:0]                 type_id,
  output logic [AW-1:0]              hit_index,
  output logic                       meta_hit,
  output logic                       meta_valid,
  output logic                       done,
  output logic                       overrun
);
  localparam int              PW         = 4 * PREFIX_DIGITS;
  localparam int              S          = (NUM_ENTRIES + LANES - 1) / LANES;
  localparam int              GW         = (S > 1) ? $clog2(S) : 1;
  localparam logic [GW-1:0]   LAST_GROUP = GW'(S - 1);
  localparam logic [3:0]      MAX_LEN    = 4'(PREFIX_DIGITS);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, PUBLISH = 2'd2} state_t;

  state_t state, state_nx;

  logic [PW-1:0]       tbl_prefix [NUM_ENTRIES];
  logic [3:0]          tbl_len    [NUM_ENTRIES];
  logic [2:0]          tbl_brand  [NUM_ENTRIES];
  logic [ISSUER_W-1:0] tbl_issuer [NUM_ENTRIES];
  logic [1:0]          tbl_type   [NUM_ENTRIES];

  logic [PW-1:0] cap_prefix;
  logic [3:0]    best_len, cand_len;
  logic [AW-1:0] best_idx, cand_idx;
  logic [GW-1:0] group;
  logic [3:0]    d0, d1;
  logic [2:0]    fallback_brand;
  logic          wr_ok;

  // Rule e matches when enabled and its first len digits equal the PAN's.
  function automatic logic entry_match(input logic [PW-1:0] pan,
                                       input logic [PW-1:0] rule,
                                       input logic [3:0]    len);
    logic ok;
    ok = (len != 4'd0);
    for (int i = 0; i < PREFIX_DIGITS; i++) begin
      if ((4'(i) < len) && (pan[4*i +: 4] != rule[4*i +: 4])) ok = 1'b0;
    end
    return ok;
  endfunction

  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE);
  assign wr_ok     = cfg_we && cfg_ready && (int'(cfg_addr) < NUM_ENTRIES);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: start aborts a scan; a valid card in idle always launches one.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (card_done && luhn_valid) state_nx = SCAN;
      SCAN:    if (start) state_nx = IDLE;
               else if (group == LAST_GROUP) state_nx = PUBLISH;
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Rule table; lengths beyond the compared digit count are clamped on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tbl_prefix[e] <= '0;
        tbl_len[e]    <= '0;
        tbl_brand[e]  <= '0;
        tbl_issuer[e] <= '0;
        tbl_type[e]   <= '0;
      end
    end else if (wr_ok) begin
      tbl_prefix[cfg_addr] <= cfg_prefix;
      tbl_len[cfg_addr]    <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
      tbl_brand[cfg_addr]  <= cfg_brand;
      tbl_issuer[cfg_addr] <= cfg_issuer;
      tbl_type[cfg_addr]   <= cfg_type;
    end
  end

  // Fold this group's lanes into the running best; strict '>' keeps the lowest index on ties.
  always_comb begin
    int idx;
    cand_len = best_len;
    cand_idx = best_idx;
    idx      = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(group) * LANES + l;
      if (idx < NUM_ENTRIES) begin
        if (entry_match(cap_prefix, tbl_prefix[AW'(idx)], tbl_len[AW'(idx)]) &&
            (tbl_len[AW'(idx)] > cand_len)) begin
          cand_len = tbl_len[AW'(idx)];
          cand_idx = AW'(idx);
        end
      end
    end
  end

  // Brand guess from the leading digits when no rule matches.
  always_comb begin
    d0 = cap_prefix[3:0];
    d1 = 4'hf;
    for (int i = 1; i < 2 && i < PREFIX_DIGITS; i++) d1 = cap_prefix[4*i +: 4];
    fallback_brand = 3'd0;
    if (d0 == 4'd4)                                   fallback_brand = 3'd1;
    else if (d0 == 4'd5)                              fallback_brand = 3'd2;
    else if (d0 == 4'd3 && (d1 == 4'd4 || d1 == 4'd7)) fallback_brand = 3'd3;
    else if (d0 == 4'd6)                              fallback_brand = 3'd4;
  end

  // Capture, scan bookkeeping and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_prefix <= '0;
      best_len   <= '0;
      best_idx   <= '0;
      group      <= '0;
      brand_id   <= '0;
      issuer_id  <= '0;
      type_id    <= '0;
      hit_index  <= '0;
      meta_hit   <= 1'b0;
      meta_valid <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        brand_id   <= '0;
        issuer_id  <= '0;
        type_id    <= '0;
        hit_index  <= '0;
        meta_hit   <= 1'b0;
        meta_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (card_done && luhn_valid) begin
            cap_prefix <= prefix_bcd;
            best_len   <= '0;
            best_idx   <= '0;
            group      <= '0;
          end else if (card_done) begin
            brand_id   <= '0;
            issuer_id  <= '0;
            type_id    <= '0;
            hit_index  <= '0;
            meta_hit   <= 1'b0;
            meta_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        SCAN: begin
          if (!start) begin
            if (card_done) overrun <= 1'b1;
            best_len <= cand_len;
            best_idx <= cand_idx;
            group    <= group + 1'b1;
          end
        end
        PUBLISH: begin
          if (!start) begin
            if (card_done) overrun <= 1'b1;
            meta_valid <= 1'b1;
            done       <= 1'b1;
            hit_index  <= best_idx;
            if (best_len != 4'd0) begin
              brand_id  <= tbl_brand[best_idx];
              issuer_id <= tbl_issuer[best_idx];
              type_id   <= tbl_type[best_idx];
              meta_hit  <= 1'b1;
            end else begin
              brand_id  <= fallback_brand;
              issuer_id <= '0;
              type_id   <= '0;
              meta_hit  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iin_table_classifier.sv
// Bench for iin_table_classifier: directed scenarios followed by a randomized
// table/card mix, all checked against a whole-table reference model.
module tb_iin_table_classifier;
  localparam int N  = 32;
  localparam int L  = 4;
  localparam int PD = 6;
  localparam int IW = 5;
  localparam int AW = 5;
  localparam int S  = (N + L - 1) / L;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, card_done = 1'b0, luhn_valid = 1'b0;
  logic [4*PD-1:0] prefix_bcd = '0, cfg_prefix = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_len = '0;
  logic [2:0]    cfg_brand = '0;
  logic [IW-1:0] cfg_issuer = '0;
  logic [1:0]    cfg_type = '0;
  logic          cfg_ready, busy, meta_hit, meta_valid, done, overrun;
  logic [2:0]    brand_id;
  logic [IW-1:0] issuer_id;
  logic [1:0]    type_id;
  logic [AW-1:0] hit_index;

  iin_table_classifier #(.NUM_ENTRIES(N), .LANES(L), .PREFIX_DIGITS(PD), .ISSUER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .card_done(card_done), .luhn_valid(luhn_valid),
    .prefix_bcd(prefix_bcd), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_prefix(cfg_prefix),
    .cfg_len(cfg_len), .cfg_brand(cfg_brand), .cfg_issuer(cfg_issuer), .cfg_type(cfg_type),
    .cfg_ready(cfg_ready), .busy(busy), .brand_id(brand_id), .issuer_id(issuer_id),
    .type_id(type_id), .hit_index(hit_index), .meta_hit(meta_hit), .meta_valid(meta_valid),
    .done(done), .overrun(overrun)
  );

  int compared = 0;
  int mismatched = 0;

  // ---------------- reference model ----------------
  int          m_len    [N];
  logic [23:0] m_prefix [N];
  int          m_brand  [N];
  int          m_issuer [N];
  int          m_type   [N];

  // Digits written most-significant-first ('h452012) become nibble0 = first digit.
  function automatic logic [23:0] pack6(input logic [23:0] msd);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = msd[4*(5-i) +: 4];
    return r;
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < N; e++) begin
      m_len[e] = 0; m_prefix[e] = '0; m_brand[e] = 0; m_issuer[e] = 0; m_type[e] = 0;
    end
  endfunction

  function automatic void model_write(input int addr, input logic [23:0] pfx, input int len,
                                      input int br, input int iss, input int ty);
    if (addr < N) begin
      m_prefix[addr] = pfx;
      m_len[addr]    = (len > PD) ? PD : len;
      m_brand[addr]  = br;
      m_issuer[addr] = iss;
      m_type[addr]   = ty;
    end
  endfunction

  function automatic void model_classify(input logic [23:0] pan, output int br, output int iss,
                                         output int ty, output int idx, output int hit);
    int best_len;
    bit m;
    best_len = 0; br = 0; iss = 0; ty = 0; idx = 0; hit = 0;
    for (int e = 0; e < N; e++) begin
      m = (m_len[e] != 0);
      for (int i = 0; i < m_len[e]; i++)
        if (pan[4*i +: 4] != m_prefix[e][4*i +: 4]) m = 0;
      if (m && m_len[e] > best_len) begin
        best_len = m_len[e]; idx = e; hit = 1;
        br = m_brand[e]; iss = m_issuer[e]; ty = m_type[e];
      end
    end
    if (hit == 0) begin
      case (pan[3:0])
        4'd4: br = 1;
        4'd5: br = 2;
        4'd3: br = (pan[7:4] == 4'd4 || pan[7:4] == 4'd7) ? 3 : 0;
        4'd6: br = 4;
        default: br = 0;
      endcase
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [23:0] pan, input logic lv);
    int br, iss, ty, idx, hit;
    br = 0; iss = 0; ty = 0; idx = 0; hit = 0;
    if (lv) model_classify(pan, br, iss, ty, idx, hit);
    chk({tag, " brand"}, brand_id, br);
    chk({tag, " issuer"}, issuer_id, iss);
    chk({tag, " type"}, type_id, ty);
    chk({tag, " hit_index"}, hit_index, idx);
    chk({tag, " meta_hit"}, meta_hit, hit);
    chk({tag, " meta_valid"}, meta_valid, lv);
  endtask

  // ---------------- driver tasks ----------------
  task automatic table_write(input int addr, input logic [23:0] pfx, input int len,
                             input int br, input int iss, input int ty);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_prefix = pfx; cfg_len = 4'(len);
    cfg_brand = 3'(br); cfg_issuer = IW'(iss); cfg_type = 2'(ty);
    @(negedge clk);
    cfg_we = 1'b0;
    model_write(addr, pfx, len, br, iss, ty);
  endtask

  // Leaves the bench at the negedge just after the edge that sampled card_done.
  task automatic pulse_card(input logic [23:0] pan, input logic lv);
    @(negedge clk);
    card_done = 1'b1; luhn_valid = lv; prefix_bcd = pan;
    @(negedge clk);
    card_done = 1'b0; luhn_valid = 1'b0;
  endtask

  // Returns the number of edges after the card_done edge at which done is seen.
  task automatic wait_done(input int n0, output int lat);
    lat = -1;
    for (int n = n0 + 1; n <= n0 + 30; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic valid_card(input string tag, input logic [23:0] pan);
    int lat;
    pulse_card(pan, 1'b1);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " cfg_ready"}, cfg_ready, 0);
    wait_done(0, lat);
    chk({tag, " latency"}, lat, S + 1);
    check_fields(tag, pan, 1'b1);
    @(negedge clk);
    chk({tag, " done width"}, done, 0);
  endtask

  task automatic invalid_card(input string tag, input logic [23:0] pan);
    pulse_card(pan, 1'b0);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    check_fields(tag, pan, 1'b0);
    @(negedge clk);
    chk({tag, " done width"}, done, 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " cfg_ready"}, cfg_ready, 1);
    chk({tag, " overrun"}, overrun, 0);
    chk({tag, " done"}, done, 0);
    check_fields(tag, 24'h0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, cnt, e, keep;
    logic [23:0] pan, pa, pb;
    model_clear();

    // Reset values
    repeat (3) @(negedge clk);
    check_cleared("in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("after reset");

    // Single rule, basic hit
    table_write(0, pack6(24'h452000), 4, 1, 1, 1);
    valid_card("entry0", pack6(24'h452012));

    // Longest match wins, ties go to the lower index, clamped length ties too
    table_write(3, pack6(24'h450000), 2, 1, 7, 1);
    table_write(9, pack6(24'h453600), 4, 1, 5, 2);
    valid_card("longest", pack6(24'h453612));
    table_write(12, pack6(24'h453600), 4, 1, 6, 3);
    valid_card("tie", pack6(24'h453612));
    valid_card("short only", pack6(24'h459999));
    table_write(19, pack6(24'h453612), 6, 2, 9, 1);
    table_write(20, pack6(24'h453612), 15, 3, 10, 2);
    valid_card("len clamp", pack6(24'h453612));

    // Luhn-invalid card after a valid result
    invalid_card("luhn0", pack6(24'h452012));

    // Write and second card while scanning
    pa = pack6(24'h452012);
    pb = pack6(24'h453612);
    pulse_card(pa, 1'b1);
    cfg_we = 1'b1; cfg_addr = '0; cfg_prefix = pack6(24'h999999); cfg_len = 4'd6;
    cfg_brand = 3'd2; cfg_issuer = 5'd3; cfg_type = 2'd3;
    chk("scan cfg_ready", cfg_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    card_done = 1'b1; luhn_valid = 1'b1; prefix_bcd = pack6(24'h650000);
    @(negedge clk);
    card_done = 1'b0; luhn_valid = 1'b0;
    chk("overrun set", overrun, 1);
    chk("overrun busy", busy, 1);
    wait_done(2, lat);
    chk("overrun latency", lat, S + 1);
    check_fields("first card", pa, 1'b1);
    chk("overrun sticky", overrun, 1);

    // start aborts a scan with no done pulse and clears everything
    pulse_card(pb, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_cleared("abort");
    count_done(15, cnt);
    chk("abort no done", cnt, 0);

    // start together with card_done while busy: abort only, no overrun
    valid_card("pre abort2", pa);
    pulse_card(pb, 1'b1);
    @(negedge clk);
    start = 1'b1; card_done = 1'b1; luhn_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; card_done = 1'b0; luhn_valid = 1'b0;
    check_cleared("abort2");
    count_done(15, cnt);
    chk("abort2 no done", cnt, 0);

    // start together with card_done while idle: clear then scan
    @(negedge clk);
    start = 1'b1; card_done = 1'b1; luhn_valid = 1'b1; prefix_bcd = pb;
    @(negedge clk);
    start = 1'b0; card_done = 1'b0; luhn_valid = 1'b0;
    chk("start+card busy", busy, 1);
    wait_done(0, lat);
    chk("start+card latency", lat, S + 1);
    check_fields("start+card", pb, 1'b1);

    // The write offered mid-scan must not have landed
    valid_card("dropped write", pa);

    // Reset in the middle of a scan
    pulse_card(pa, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("mid-scan reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    valid_card("after reset", pa);

    // Empty table fallback brands
    valid_card("fb amex", pack6(24'h371234));
    valid_card("fb amex34", pack6(24'h341234));
    valid_card("fb mc", pack6(24'h511234));
    valid_card("fb disc", pack6(24'h651234));
    valid_card("fb unknown", pack6(24'h912345));
    valid_card("fb 35", pack6(24'h351234));

    // Randomized table and cards
    for (int w = 0; w < 40; w++) begin
      pan = '0;
      for (int i = 0; i < 6; i++)
        pan[4*i +: 4] = (i < 3) ? 4'($urandom_range(3, 6)) : 4'($urandom_range(0, 9));
      table_write($urandom_range(0, N - 1), pan, $urandom_range(0, 8), $urandom_range(0, 4),
                  $urandom_range(0, 31), $urandom_range(0, 3));
    end
    for (int c = 0; c < 30; c++) begin
      e = $urandom_range(0, N - 1);
      pan = m_prefix[e];
      keep = $urandom_range(0, 6);
      for (int i = keep; i < 6; i++) pan[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) invalid_card("rand inv", pan);
      else valid_card("rand", pan);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
